encoder8to3_queue: RTL and testbench

- Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Captures one-hot or multi-hot request pulses on an 8-bit input into a pending register.
- Emits the 3-bit index of one pending request at a time on a valid/ready handshake, by fixed-priority or round-robin selection.
- Sits upstream of the decoder: its code/enable outputs feed the decoder's in/enable.

---
 rtl/encoder8to3_queue_pkg.sv | 17 +
 rtl/encoder8to3_queue_pick8.sv | 36 +++
 rtl/encoder8to3_queue.sv | 69 ++++++
 tb/tb_encoder8to3_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder8to3_queue_pkg.sv
// Shared sizes, selection-policy constants and helpers for the 8-to-3 request encoder.
package encoder_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic [N_REQ-1:0] onehot(idx_t i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/encoder8to3_queue_pick8.sv
// Combinational picker: highest set index (fixed) or first set index at/after ptr (round-robin).
module pick8
  import encoder_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [2:0] i_ptr,
  input  logic       i_mode,
  output logic [2:0] o_idx,
  output logic       o_any
);

  idx_t w_fix;
  idx_t w_rr;
  idx_t w_j;

  always_comb begin
    w_fix = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (i_req[k]) w_fix = idx_t'(k);
    end
  end

  // Walk offsets from farthest to nearest so the closest set bit after ptr is the last write.
  always_comb begin
    w_rr = '0;
    w_j  = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      w_j = i_ptr + idx_t'(k - 1);
      if (i_req[w_j]) w_rr = w_j;
    end
  end

  assign o_any = |i_req;
  assign o_idx = (i_mode == MODE_RR) ? w_rr : w_fix;

endmodule

// File: rtl/encoder8to3_queue.sv
// Sequential 8-to-3 encoder: accumulates request pulses and issues one index per valid/ready handshake.
module encoder8to3_queue
  import encoder_pkg::*;
#(
  parameter logic RR_MODE = MODE_FIXED
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic       merge
);

  logic [N_REQ-1:0] r_pend;
  idx_t             r_out;
  logic             r_valid;
  logic             r_merge;
  idx_t             r_ptr;

  logic [N_REQ-1:0] w_pend_next;
  logic [N_REQ-1:0] w_clr;
  idx_t             w_idx;
  logic             w_any;
  logic             w_load;

  assign w_pend_next = enable ? (r_pend | in) : r_pend;

  pick8 u_pick (
    .i_req  (w_pend_next),
    .i_ptr  (r_ptr),
    .i_mode (RR_MODE),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_load = enable && (!r_valid || ready) && w_any;
  assign w_clr  = w_load ? onehot(w_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_merge <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_pend  <= w_pend_next & ~w_clr;
      r_merge <= enable && ((in & r_pend) != '0);
      if (w_load) begin
        r_out   <= w_idx;
        r_valid <= 1'b1;
        r_ptr   <= w_idx + 3'd1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out     = r_out;
  assign valid   = r_valid;
  assign pending = r_pend;
  assign merge   = r_merge;

endmodule

// File: tb/tb_encoder8to3_queue.sv
// Bench for encoder8to3_queue: both selection policies run side by side against a queue-level model.
module tb_encoder8to3_queue;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       rdy;
    logic [7:0] in;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] in = '0;

  logic [2:0] d_out   [2];
  logic       d_valid [2];
  logic [7:0] d_pend  [2];
  logic       d_merge [2];

  logic [7:0] p_req = '0;
  logic [2:0] p_ptr = '0;
  logic       p_mode = 1'b0;
  logic [2:0] p_idx;
  logic       p_any;

  int n_checks = 0;
  int n_fail   = 0;

  int m_pend  [2];
  int m_out   [2];
  int m_valid [2];
  int m_merge [2];
  int m_ptr   [2];

  always #5 clk = ~clk;

  encoder8to3_queue #(.RR_MODE(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(d_out[0]),
    .valid(d_valid[0]), .ready(ready), .pending(d_pend[0]), .merge(d_merge[0])
  );

  encoder8to3_queue #(.RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .enable(enable), .in(in), .out(d_out[1]),
    .valid(d_valid[1]), .ready(ready), .pending(d_pend[1]), .merge(d_merge[1])
  );

  pick8 u_ref_pick (
    .i_req(p_req), .i_ptr(p_ptr), .i_mode(p_mode), .o_idx(p_idx), .o_any(p_any)
  );

  // Policy 0: highest set bit. Policy 1: first set bit scanning upward from ptr with wrap.
  function automatic int choose(int v, int mode, int ptr);
    if (mode == 0) begin
      for (int i = 7; i >= 0; i--) if (v[i]) return i;
    end else begin
      for (int k = 0; k < 8; k++) if (v[(ptr + k) % 8]) return (ptr + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [12:0] exp_vec(int m);
    return {3'(m_out[m]), 1'(m_valid[m]), 8'(m_pend[m]), 1'(m_merge[m])};
  endfunction

  function automatic logic [12:0] obs_vec(int m);
    return {d_out[m], d_valid[m], d_pend[m], d_merge[m]};
  endfunction

  task automatic cycle(input stim_t s);
    int pn, sel;
    rst = s.rst; enable = s.en; ready = s.rdy; in = s.in;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (s.rst) begin
        m_pend[m] = 0; m_out[m] = 0; m_valid[m] = 0; m_merge[m] = 0; m_ptr[m] = 0;
      end else begin
        pn = s.en ? (m_pend[m] | int'(s.in)) : m_pend[m];
        m_merge[m] = (s.en && ((m_pend[m] & int'(s.in)) != 0)) ? 1 : 0;
        if (s.en && (!m_valid[m] || s.rdy) && pn != 0) begin
          sel = choose(pn, m, m_ptr[m]);
          m_out[m] = sel;
          m_valid[m] = 1;
          pn = pn & ~(1 << sel);
          m_ptr[m] = (sel + 1) % 8;
        end else if (m_valid[m] && s.rdy) begin
          m_valid[m] = 0;
        end
        m_pend[m] = pn;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    stim_t st;
    for (int c = 0; c < 3; c++) begin
      st = '{rst: (c < 2), en: 1'b1, rdy: 1'b1, in: (c < 2) ? 8'hFF : 8'h00};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== 13'h0) begin
          n_fail++;
          $display("FAIL reset_state mode%0d cyc%0d: got {out,valid,pend,merge}=%h want 0", m, c, obs_vec(m));
        end
      end
    end
  endtask

  task automatic test_fixed_drain();
    stim_t st;
    int seq[4] = '{7, 5, 2, 0};
    for (int c = 0; c < 6; c++) begin
      st = '{rst: 1'b0, en: 1'b1, rdy: 1'b1, in: (c == 0) ? 8'hA5 : 8'h00};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL drain_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
      end
      n_checks++;
      if (c < 4 && (d_out[0] !== 3'(seq[c]) || d_valid[0] !== 1'b1)) begin
        n_fail++;
        $display("FAIL drain_seq cyc%0d: got out=%0d valid=%b want out=%0d valid=1", c, d_out[0], d_valid[0], seq[c]);
      end else if (c >= 4 && (d_valid[0] !== 1'b0 || d_pend[0] !== 8'h00)) begin
        n_fail++;
        $display("FAIL drain_idle cyc%0d: got valid=%b pend=%h want valid=0 pend=00", c, d_valid[0], d_pend[0]);
      end
    end
  endtask

  task automatic test_rr_wrap();
    stim_t st;
    logic [7:0] ins[7] = '{8'h40, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    int seq[4] = '{7, 0, 1, 6};
    for (int c = 0; c < 7; c++) begin
      st = '{rst: 1'b0, en: 1'b1, rdy: 1'b1, in: ins[c]};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL rr_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
      end
      if (c >= 2 && c <= 5) begin
        n_checks++;
        if (d_out[1] !== 3'(seq[c-2]) || d_valid[1] !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_seq cyc%0d: got out=%0d valid=%b want out=%0d valid=1", c, d_out[1], d_valid[1], seq[c-2]);
        end
      end
    end
  endtask

  task automatic test_stall_merge();
    stim_t st;
    logic [7:0] ins[6] = '{8'h08, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00};
    logic       rdy[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 6; c++) begin
      st = '{rst: 1'b0, en: 1'b1, rdy: rdy[c], in: ins[c]};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL stall_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
        n_checks++;
        if ((c == 2 && {d_merge[m], d_out[m], d_valid[m]} !== {1'b1, 3'd3, 1'b1}) ||
            (c == 3 && {d_merge[m], d_out[m], d_valid[m]} !== {1'b0, 3'd3, 1'b1}) ||
            (c == 4 && {d_out[m], d_valid[m]} !== {3'd4, 1'b1}) ||
            (c == 5 && {d_valid[m], d_pend[m]} !== {1'b0, 8'h00})) begin
          n_fail++;
          $display("FAIL stall_direct mode%0d cyc%0d: got merge=%b out=%0d valid=%b pend=%h", m, c, d_merge[m], d_out[m], d_valid[m], d_pend[m]);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    stim_t st;
    logic [7:0] ins[3] = '{8'h02, 8'h80, 8'h00};
    logic       ens[3] = '{1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 3; c++) begin
      st = '{rst: 1'b0, en: ens[c], rdy: 1'b1, in: ins[c]};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL enable_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
        n_checks++;
        if (c > 0 && {d_valid[m], d_pend[m], d_merge[m]} !== 10'h0) begin
          n_fail++;
          $display("FAIL enable_idle mode%0d cyc%0d: got valid=%b pend=%h merge=%b want all 0", m, c, d_valid[m], d_pend[m], d_merge[m]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t st;
    logic [7:0] ins[5] = '{8'h10, 8'h0F, 8'h00, 8'h00, 8'h00};
    logic       rs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       rdy[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 5; c++) begin
      st = '{rst: rs[c], en: 1'b1, rdy: rdy[c], in: ins[c]};
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL rstmid_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
        n_checks++;
        if ((c == 1 && {d_pend[m], d_valid[m], d_out[m]} !== {8'h0F, 1'b1, 3'd4}) ||
            (c >= 2 && obs_vec(m) !== 13'h0)) begin
          n_fail++;
          $display("FAIL rstmid_direct mode%0d cyc%0d: got {out,valid,pend,merge}=%h", m, c, obs_vec(m));
        end
      end
    end
  endtask

  task automatic test_random_traffic();
    stim_t st;
    for (int c = 0; c < 600; c++) begin
      st.rst = ($urandom_range(0, 63) == 0);
      st.en  = ($urandom_range(0, 7) != 0);
      st.rdy = ($urandom_range(0, 2) != 0);
      st.in  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      cycle(st);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (obs_vec(m) !== exp_vec(m)) begin
          n_fail++;
          $display("FAIL random_model mode%0d cyc%0d: got %h want %h", m, c, obs_vec(m), exp_vec(m));
        end
      end
    end
  endtask

  task automatic test_pick8();
    int want;
    for (int t = 0; t < 200; t++) begin
      p_req  = (t % 16 == 0) ? 8'h00 : 8'($urandom);
      p_ptr  = 3'($urandom);
      p_mode = 1'(t % 2);
      #1;
      want = choose(int'(p_req), int'(p_mode), int'(p_ptr));
      n_checks++;
      if (p_any !== (want >= 0) || (want >= 0 && p_idx !== 3'(want))) begin
        n_fail++;
        $display("FAIL pick8 req=%h ptr=%0d mode=%b: got idx=%0d any=%b want idx=%0d", p_req, p_ptr, p_mode, p_idx, p_any, want);
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 0; m_out[m] = 0; m_valid[m] = 0; m_merge[m] = 0; m_ptr[m] = 0;
    end
    test_reset();
    test_fixed_drain();
    test_rr_wrap();
    test_stall_merge();
    test_enable_gating();
    test_reset_mid();
    test_random_traffic();
    test_pick8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
